// File: rtl/mem_arb_pkg.sv
// Shared encodings and widths for the I/D memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    // Sized for LATENCY up to 15 and MAX_STREAK up to 7.
    localparam int CNT_W    = 4;
    localparam int STREAK_W = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between I and D with a streak limit that keeps I from starving.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_STREAK = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic                d_req,
    input  logic                accept,
    output logic                grant,
    output logic [STREAK_W-1:0] streak
);

    logic at_limit;

    assign at_limit = (streak == STREAK_W'(MAX_STREAK));

    // D wins unless I is waiting and D has already used up its streak.
    always_comb begin
        grant = GNT_I;
        if (d_req && !(i_req && at_limit)) begin
            grant = GNT_D;
        end else begin
            grant = GNT_I;
        end
    end

    // Count consecutive D grants that left I waiting, saturating at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= {STREAK_W{1'b0}};
        end else if (accept) begin
            if ((grant == GNT_D) && i_req) begin
                streak <= at_limit ? streak : (streak + STREAK_W'(1));
            end else begin
                streak <= {STREAK_W{1'b0}};
            end
        end else begin
            streak <= streak;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch (I)
// and data access (D); one transaction at a time, done pulse on completion.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int MAX_STREAK = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_done,
    output logic [15:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_done,
    output logic [15:0] d_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic               gnt;
    logic               win;
    logic               accept;
    logic               last_beat;
    logic               lat_wr;
    logic [15:0]        lat_addr;
    logic [15:0]        lat_wdata;
    logic               win_wr;
    logic [15:0]        win_addr;
    logic [15:0]        win_wdata;

    assign last_beat = (cnt == CNT_W'(LATENCY - 1));
    assign win_addr  = (win == GNT_D) ? d_addr  : i_addr;
    assign win_wdata = (win == GNT_D) ? d_wdata : 16'h0000;
    assign win_wr    = (win == GNT_D) ? d_wr    : 1'b0;

    // Latched transaction drives the memory bus directly so it cannot move mid-access.
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    mem_arb_pick #(
        .MAX_STREAK (MAX_STREAK)
    ) u_pick (
        .clk    (clk),
        .rst    (rst),
        .i_req  (i_req),
        .d_req  (d_req),
        .accept (accept),
        .grant  (win),
        .streak ()
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; requests are only looked at while idle.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    next_state = BUSY;
                    accept     = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            BUSY: begin
                if (last_beat) begin
                    next_state = RESP;
                end else begin
                    next_state = BUSY;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Transaction latches, beat counter, read capture and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= {CNT_W{1'b0}};
            gnt       <= GNT_I;
            lat_wr    <= 1'b0;
            lat_addr  <= 16'h0000;
            lat_wdata <= 16'h0000;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            busy      <= 1'b0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            i_rdata   <= 16'h0000;
            d_rdata   <= 16'h0000;
        end else begin
            busy   <= (next_state != IDLE);
            mem_en <= (next_state == BUSY);
            i_done <= (state == BUSY) && last_beat && (gnt == GNT_I);
            d_done <= (state == BUSY) && last_beat && (gnt == GNT_D);
            if (accept) begin
                lat_addr  <= win_addr;
                lat_wdata <= win_wdata;
                lat_wr    <= win_wr;
                gnt       <= win;
                mem_wr    <= win_wr;
                cnt       <= {CNT_W{1'b0}};
            end else begin
                mem_wr <= lat_wr && (next_state == BUSY);
                cnt    <= (state == BUSY) ? (cnt + CNT_W'(1)) : {CNT_W{1'b0}};
            end
            // mem_rdata is only guaranteed on the final beat.
            if ((state == BUSY) && last_beat && !lat_wr) begin
                if (gnt == GNT_D) begin
                    d_rdata <= mem_rdata;
                end else begin
                    i_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized I/D traffic against a transaction-timing model of the arbiter.
module tb_mem_arbiter;

    localparam int LAT  = 4;
    localparam int MAXS = 2;
    localparam int NCYC = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_done, d_done, mem_en, mem_wr, busy;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [15:0] dut_mem [0:255];
    logic [15:0] ref_mem [0:255];

    int total = 0;
    int bad   = 0;

    // model state
    bit          m_act, m_gnt, m_wr;
    int          m_start, m_idle_from, m_streak;
    logic [15:0] m_addr, m_wdata, m_rdata, e_ird, e_drd;
    bit          i_pend, d_pend, i_acc, d_acc, in_busy, in_resp, do_rst, mid_rst_done;
    int          run_len, beat, cyc;

    always #5 clk = ~clk;

    mem_arbiter #(.LATENCY(LAT), .MAX_STREAK(MAXS)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    initial begin
        logic [15:0] v;
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        i_addr = 16'h0000; d_addr = 16'h0000; d_wdata = 16'h0000; mem_rdata = 16'h0000;
        for (int i = 0; i < 256; i++) begin
            v = 16'($urandom);
            dut_mem[i] = v;
            ref_mem[i] = v;
        end
        ref_mem[8'h10] = 16'hA55A; dut_mem[8'h10] = 16'hA55A;
        m_act = 1'b0; m_idle_from = 0; m_streak = 0; e_ird = 16'h0000; e_drd = 16'h0000;
        i_pend = 1'b0; d_pend = 1'b0; i_acc = 1'b0; d_acc = 1'b0; mid_rst_done = 1'b0;
        run_len = 0;

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            cyc = c;
            in_busy = m_act && (c > m_start) && (c <= m_start + LAT);
            in_resp = m_act && (c == m_start + LAT + 1);
            if (in_resp && !m_wr) begin
                if (m_gnt) e_drd = m_rdata;
                else       e_ird = m_rdata;
            end

            check("mem_en",  32'(mem_en), 32'(in_busy));
            check("busy",    32'(busy),   32'(in_busy || in_resp));
            check("i_done",  32'(i_done), 32'(in_resp && !m_gnt));
            check("d_done",  32'(d_done), 32'(in_resp && m_gnt));
            check("i_rdata", 32'(i_rdata), 32'(e_ird));
            check("d_rdata", 32'(d_rdata), 32'(e_drd));
            if (in_busy) begin
                check("mem_addr",  32'(mem_addr),  32'(m_addr));
                check("mem_wr",    32'(mem_wr),    32'(m_wr));
                check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            end
            if (c == 0) check("rst_addr", 32'(mem_addr), 32'h0);

            // memory: data valid only on the final beat of an access
            if (mem_en) begin
                if (mem_wr) dut_mem[mem_addr[7:0]] = mem_wdata;
                beat = run_len;
                run_len++;
            end else begin
                beat = -1;
                run_len = 0;
            end
            mem_rdata = (beat == LAT - 1) ? dut_mem[mem_addr[7:0]] : (mem_addr ^ 16'hBEEF);

            if (in_resp) begin
                if (m_gnt) begin d_pend = 1'b0; d_acc = 1'b0; end
                else       begin i_pend = 1'b0; i_acc = 1'b0; end
                m_act = 1'b0;
            end

            do_rst = (c < 2) || (c == 1700) || (!mid_rst_done && c >= 800 && in_busy);
            if (do_rst) begin
                if (c >= 800 && c != 1700) mid_rst_done = 1'b1;
                rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
                i_pend = 1'b0; d_pend = 1'b0; i_acc = 1'b0; d_acc = 1'b0;
                m_act = 1'b0; m_streak = 0; e_ird = 16'h0000; e_drd = 16'h0000;
                m_idle_from = c + 1;
            end else begin
                rst = 1'b0;
                if (c == 2) begin
                    i_pend = 1'b1; i_req = 1'b1; i_addr = 16'h0010;
                    d_pend = 1'b1; d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
                end else begin
                    if (!i_pend) begin
                        if ($urandom_range(0, 2) != 0) begin
                            i_pend = 1'b1; i_req = 1'b1; i_addr = 16'($urandom) & 16'hE01F;
                        end else i_req = 1'b0;
                    end else if (i_acc && $urandom_range(0, 7) == 0) begin
                        i_addr = 16'($urandom);
                        if ($urandom_range(0, 1) == 0) i_req = 1'b0;
                    end
                    if (!d_pend) begin
                        if ($urandom_range(0, 2) != 0) begin
                            d_pend = 1'b1; d_req = 1'b1; d_wr = 1'($urandom_range(0, 1));
                            d_addr = 16'($urandom) & 16'hE01F; d_wdata = 16'($urandom);
                        end else d_req = 1'b0;
                    end else if (d_acc && $urandom_range(0, 7) == 0) begin
                        d_addr = 16'($urandom); d_wdata = 16'($urandom); d_wr = ~d_wr;
                        if ($urandom_range(0, 1) == 0) d_req = 1'b0;
                    end
                end
                // arbitration decision taken at the edge ending this cycle
                if (!m_act && c >= m_idle_from && (i_req || d_req)) begin
                    m_gnt = d_req && !(i_req && m_streak == MAXS);
                    if (m_gnt) m_streak = i_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
                    else       m_streak = 0;
                    m_act = 1'b1; m_start = c; m_idle_from = c + LAT + 2;
                    if (m_gnt) begin
                        m_addr = d_addr; m_wr = d_wr; m_wdata = d_wdata; d_acc = 1'b1;
                    end else begin
                        m_addr = i_addr; m_wr = 1'b0; m_wdata = 16'h0000; i_acc = 1'b1;
                    end
                    if (m_wr) ref_mem[m_addr[7:0]] = m_wdata;
                    else      m_rdata = ref_mem[m_addr[7:0]];
                end
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, fixed-latency, 16-bit word memory between the instruction-fetch side (I) and the data-access side (D) of the multicycle CPU.
- Accepts one single-word request at a time, then holds the memory address, data and control stable for LATENCY cycles.
- Returns read data or write completion to the winning requester with a one-cycle done pulse.
- D has priority; a streak limit prevents I from starving.

Parameters:
- LATENCY, 4: memory access cycles; mem_rdata is valid in the last of them. Legal range 1..15.
- MAX_STREAK, 2: maximum consecutive D grants while I is waiting; the next contended grant then goes to I. Legal range 1..7.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  instruction-fetch request; held until i_done.
- i_addr  in  16  fetch address.
- i_done  out  1  one-cycle pulse; i_rdata valid.
- i_rdata  out  16  fetched word.
- d_req  in  1  data request; held until d_done.
- d_wr  in  1  1 = write, 0 = read.
- d_addr  in  16  data address.
- d_wdata  in  16  write data.
- d_done  out  1  one-cycle pulse; read data valid or write complete.
- d_rdata  out  16  read word.
- mem_en  out  1  memory enable.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data, valid in the last BUSY cycle.
- busy  out  1  high in BUSY or RESP.

Behaviour:
- Reset: synchronous, active-high. Next state is IDLE. Clears the following to 0:
  - all outputs;
  - latched addr/wdata/wr;
  - the busy-cycle counter;
  - the streak counter;
  - the grant register.
- States: IDLE, BUSY, RESP.
- IDLE, no request: stay in IDLE; mem_en=0.
- IDLE, request present:
  - At the edge, latch the winner's addr, wdata and wr, plus the grant ID.
  - Go to BUSY with cnt=0.
  - For I, wr=0 and wdata=0.
- Arbitration:
  - Only d_req: grant D.
  - Only i_req: grant I.
  - Both: grant D unless streak==MAX_STREAK, in which case grant I.
- Streak counter:
  - Increments on a D grant while i_req=1.
  - Clears on an I grant.
  - Clears on a D grant while i_req=0.
  - Saturates at MAX_STREAK.
- BUSY:
  - Drives mem_en=1 and mem_addr/mem_wdata/mem_wr from the latched values, stable every cycle.
  - cnt increments each cycle.
  - When cnt==LATENCY-1:
    - on a read, register mem_rdata into the granted side's rdata;
    - go to RESP.
- RESP:
  - The granted side's done=1 for exactly this cycle; mem_en=0.
  - Go to IDLE unconditionally.
  - Requests are not sampled in RESP.
- Latency:
  - Request first seen in IDLE at edge E0, then BUSY for cycles E0+1..E0+LATENCY, then done in cycle E0+LATENCY+1.
  - Back-to-back throughput is one transaction per LATENCY+2 cycles.
- i_rdata/d_rdata hold their last captured value between transactions. A write transaction leaves d_rdata unchanged.
- Requester input changes (addr, wdata, wr, or dropping req) during BUSY are ignored. The latched transaction completes and done still pulses.
- A requester that keeps req high after its done is re-arbitrated in the following IDLE cycle as a new request.
- Never more than one done high in the same cycle. i_done and d_done are never high outside RESP.
- rst during BUSY or RESP:
  - the transaction is dropped with no done pulse;
  - mem_en=0 from the next cycle;
  - the memory write may be partially applied (caller's responsibility).

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding (IDLE=2'b00, BUSY=2'b01, RESP=2'b10);
  - grant IDs (GNT_I=1'b0, GNT_D=1'b1);
  - counter width constants.
- One sub-module, mem_arb_pick: the streak counter plus the combinational winner selection. Inputs are i_req, d_req and the accept strobe; outputs are the grant and the streak value.
- The FSM, counter and latches stay in mem_arbiter.

Test Plan (LATENCY=4, MAX_STREAK=2):
1. I read: i_req=1, i_addr=0x0010, memory[0x0010]=0xA55A at cycle 0 -> mem_en=1, mem_addr=0x0010 in cycles 1-4; i_done=1, i_rdata=0xA55A in cycle 5 only.
2. D write then read: d_wr=1, d_addr=0x0200, d_wdata=0x1234 -> mem_wr=1 in cycles 1-4 and d_done in cycle 5. Then a read of 0x0200 -> d_rdata=0x1234, with d_done 5 cycles after acceptance.
3. Contention: i_req and d_req held high continuously -> grant order D, D, I, D, D, I; each done spaced 6 cycles apart.
4. Input change during BUSY: i_addr changes 0x0010->0x0020 in cycle 2 and i_req drops in cycle 3 -> mem_addr stays 0x0010 through cycle 4; i_done still pulses in cycle 5.
5. Reset mid-transaction: rst=1 in cycle 3 of a D read -> mem_en=0 from cycle 4; no d_done; busy=0; the next D request completes normally with streak=0.
6. Simultaneous first request from reset: i_req and d_req both rise together -> D granted; streak=1 after acceptance; i_done occurs only after d_done plus 1 IDLE cycle plus the I access.
